// File: rtl/dual_channel_fifo_pkg.sv
// Shared constants for the dual-channel buffer.
// Reused by the controller-level top.
package dual_channel_fifo_pkg;

  localparam int DEF_DATA_WIDTH = 8;
  localparam int DEF_DEPTH      = 16;

  // Pointer width needed to address depth entries.
  function automatic int addr_bits(input int depth);
    int b;
    b = 0;
    for (int i = 0; i < 31; i++)
      if ((1 << i) < depth) b = i + 1;
    return b;
  endfunction

endpackage

// File: rtl/dual_channel_fifo_mem.sv
// Simple dual-port register array.
// Synchronous write, registered read.
module fifo_mem #(
  parameter int DW = 8,
  parameter int AW = 4
) (
  input  logic          clk,
  input  logic          we,
  input  logic [AW-1:0] waddr,
  input  logic [DW-1:0] wdata,
  input  logic          re,
  input  logic [AW-1:0] raddr,
  output logic [DW-1:0] rdata
);

  logic [DW-1:0] mem [2**AW];

  // Storage is never cleared; contents past reset are stale.
  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
    if (re) rdata <= mem[raddr];
  end

endmodule

// File: rtl/dual_channel_fifo.sv
// Two-source FIFO with occupancy, flags and drop pulses.
// Mux picks the channel written on each accepted write.
module dual_channel_fifo
  import dual_channel_fifo_pkg::*;
#(
  parameter int DATA_WIDTH = DEF_DATA_WIDTH,
  parameter int DEPTH      = DEF_DEPTH,
  parameter int ADDR_WIDTH = addr_bits(DEPTH)
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  Mux,
  input  logic                  Write,
  input  logic                  Read,
  input  logic [DATA_WIDTH-1:0] Ch1_Data,
  input  logic [DATA_WIDTH-1:0] Ch2_Data,
  output logic [DATA_WIDTH-1:0] Data_Out,
  output logic                  Data_Valid,
  output logic                  Full,
  output logic                  Empty,
  output logic [ADDR_WIDTH:0]   Count,
  output logic                  Write_Drop,
  output logic                  Read_Drop
);

  localparam logic [ADDR_WIDTH:0] CNT_FULL =
    (ADDR_WIDTH+1)'(DEPTH);

  logic [ADDR_WIDTH-1:0] wr_ptr;
  logic [ADDR_WIDTH-1:0] rd_ptr;
  logic [DATA_WIDTH-1:0] wdata;
  logic [DATA_WIDTH-1:0] rdata;
  logic                  wr_en;
  logic                  rd_en;
  logic                  out_zero;

  assign Full  = (Count == CNT_FULL);
  assign Empty = (Count == '0);
  assign wr_en = Write & ~Full;
  assign rd_en = Read & ~Empty;
  assign wdata = Mux ? Ch1_Data : Ch2_Data;

  // The memory read register has no reset, so mask it
  // until the first real read after reset.
  assign Data_Out = out_zero ? '0 : rdata;

  fifo_mem #(
    .DW(DATA_WIDTH),
    .AW(ADDR_WIDTH)
  ) u_mem (
    .clk  (clk),
    .we   (wr_en),
    .waddr(wr_ptr),
    .wdata(wdata),
    .re   (rd_en),
    .raddr(rd_ptr),
    .rdata(rdata)
  );

  // Pointers wrap by natural overflow.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (wr_en) wr_ptr <= wr_ptr + ADDR_WIDTH'(1);
      if (rd_en) rd_ptr <= rd_ptr + ADDR_WIDTH'(1);
    end
  end

  // Occupancy; unchanged when both or neither accepted.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      Count <= '0;
    end else begin
      case ({wr_en, rd_en})
        2'b10:   Count <= Count + (ADDR_WIDTH+1)'(1);
        2'b01:   Count <= Count - (ADDR_WIDTH+1)'(1);
        default: Count <= Count;
      endcase
    end
  end

  // Registered strobes for the downstream consumer.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      Data_Valid <= 1'b0;
      Write_Drop <= 1'b0;
      Read_Drop  <= 1'b0;
      out_zero   <= 1'b1;
    end else begin
      Data_Valid <= rd_en;
      Write_Drop <= Write & Full;
      Read_Drop  <= Read & Empty;
      if (rd_en) out_zero <= 1'b0;
    end
  end

endmodule

// File: tb/tb_dual_channel_fifo.sv
// Randomized self-checking bench for dual_channel_fifo.
// A queue model predicts contents, flags and strobes.
module tb_dual_channel_fifo;
  import dual_channel_fifo_pkg::*;

  localparam int DW = DEF_DATA_WIDTH;
  localparam int D  = DEF_DEPTH;
  localparam int AW = addr_bits(DEF_DEPTH);

  logic          clk = 1'b0;
  logic          reset;
  logic          Mux, Write, Read;
  logic [DW-1:0] Ch1_Data, Ch2_Data, Data_Out;
  logic          Data_Valid, Full, Empty;
  logic          Write_Drop, Read_Drop;
  logic [AW:0]   Count;

  int checks = 0;
  int errors = 0;

  logic [DW-1:0] q[$];
  logic [DW-1:0] e_out;
  logic          e_valid, e_wd, e_rd;
  logic [AW+5:0] st, e_st;

  assign st = {Count, Full, Empty, Data_Valid,
               Write_Drop, Read_Drop};

  dual_channel_fifo dut (
    .clk       (clk),
    .reset     (reset),
    .Mux       (Mux),
    .Write     (Write),
    .Read      (Read),
    .Ch1_Data  (Ch1_Data),
    .Ch2_Data  (Ch2_Data),
    .Data_Out  (Data_Out),
    .Data_Valid(Data_Valid),
    .Full      (Full),
    .Empty     (Empty),
    .Count     (Count),
    .Write_Drop(Write_Drop),
    .Read_Drop (Read_Drop)
  );

  always #5 clk = ~clk;

  function automatic logic [AW+5:0] model_st();
    return {(AW+1)'(q.size()), q.size() == D,
            q.size() == 0, e_valid, e_wd, e_rd};
  endfunction

  task automatic cycle(input logic w, input logic r,
                       input logic m,
                       input logic [DW-1:0] c1,
                       input logic [DW-1:0] c2);
    bit wacc, racc;
    Write = w; Read = r; Mux = m;
    Ch1_Data = c1; Ch2_Data = c2;
    wacc = w && (q.size() < D);
    racc = r && (q.size() > 0);
    e_wd = w && !wacc;
    e_rd = r && !racc;
    e_valid = racc;
    if (racc) e_out = q.pop_front();
    if (wacc) q.push_back(m ? c1 : c2);
    e_st = model_st();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    cycle(1'b0, 1'b0, 1'b0, DW'($urandom), DW'($urandom));
  endtask

  task automatic test_reset();
    Write = 0; Read = 0; Mux = 0;
    Ch1_Data = 0; Ch2_Data = 0;
    reset = 1'b0;
    q.delete(); e_out = '0;
    e_valid = 0; e_wd = 0; e_rd = 0;
    #2;
    checks++;
    if (st !== {(AW+1)'(0), 5'b01000}) begin
      errors++;
      $display("FAIL reset_status got %h want %h",
               st, {(AW+1)'(0), 5'b01000});
    end
    checks++;
    if (Data_Out !== '0) begin
      errors++;
      $display("FAIL reset_data got %h want 00", Data_Out);
    end
    repeat (2) @(posedge clk);
    @(negedge clk);
    reset = 1'b1;
    idle();
  endtask

  task automatic test_fill_overflow();
    for (int i = 0; i < D; i++) begin
      cycle(1'b1, 1'b0, 1'b1, DW'(8'hA0 + i), DW'($urandom));
      checks++;
      if (Count !== (AW+1)'(i + 1) ||
          Full !== (i == D - 1)) begin
        errors++;
        $display("FAIL fill_count i=%0d got %0d/%b want %0d",
                 i, Count, Full, i + 1);
      end
    end
    cycle(1'b1, 1'b0, 1'b1, 8'hFF, 8'h00);
    checks++;
    if (st !== e_st || Write_Drop !== 1'b1) begin
      errors++;
      $display("FAIL fill_overflow got %h want %h", st, e_st);
    end
  endtask

  task automatic test_drain_underflow();
    for (int i = 0; i <= D; i++) begin
      cycle(1'b0, 1'b1, 1'b0, 8'h00, 8'h00);
      checks++;
      if (st !== e_st ||
          Data_Out !== DW'(8'hA0 + (i < D ? i : D - 1))) begin
        errors++;
        $display("FAIL drain i=%0d got %h/%h want %h/%h",
                 i, st, Data_Out, e_st, e_out);
      end
    end
    checks++;
    if (Read_Drop !== 1'b1 || Empty !== 1'b1 ||
        Data_Out !== 8'hAF) begin
      errors++;
      $display("FAIL underflow got rd=%b e=%b d=%h want 1 1 af",
               Read_Drop, Empty, Data_Out);
    end
  endtask

  task automatic test_mux_select();
    logic [DW-1:0] exp_seq [3];
    exp_seq[0] = 8'h11; exp_seq[1] = 8'h22; exp_seq[2] = 8'h33;
    idle();
    cycle(1'b1, 1'b0, 1'b1, 8'h11, 8'hEE);
    cycle(1'b1, 1'b0, 1'b0, 8'hDD, 8'h22);
    cycle(1'b1, 1'b0, 1'b1, 8'h33, 8'hCC);
    for (int i = 0; i < 3; i++) begin
      cycle(1'b0, 1'b1, 1'b0, 8'h00, 8'h00);
      checks++;
      if (Data_Out !== exp_seq[i] || Data_Valid !== 1'b1) begin
        errors++;
        $display("FAIL mux_order i=%0d got %h/%b want %h/1",
                 i, Data_Out, Data_Valid, exp_seq[i]);
      end
    end
  endtask

  task automatic test_back_to_back();
    for (int i = 0; i < 10; i++)
      cycle(1'b1, 1'b0, 1'b0, DW'($urandom), DW'(i));
    for (int i = 0; i < 20; i++) begin
      cycle(1'b1, 1'b1, 1'b1, DW'(10 + i), DW'($urandom));
      checks++;
      if (st !== e_st || Data_Out !== e_out ||
          Count !== (AW+1)'(10) || Data_Out !== DW'(i)) begin
        errors++;
        $display("FAIL b2b i=%0d got %h/%h want %h/%h",
                 i, st, Data_Out, e_st, DW'(i));
      end
    end
    while (q.size() > 0) cycle(1'b0, 1'b1, 1'b0, 0, 0);
    idle();
  endtask

  task automatic test_empty_simul();
    cycle(1'b1, 1'b1, 1'b0, 8'h99, 8'h5A);
    checks++;
    if (Count !== (AW+1)'(1) || Read_Drop !== 1'b1 ||
        Data_Valid !== 1'b0) begin
      errors++;
      $display("FAIL empty_simul got c=%0d rd=%b v=%b want 1 1 0",
               Count, Read_Drop, Data_Valid);
    end
    cycle(1'b0, 1'b1, 1'b0, 8'h00, 8'h00);
    checks++;
    if (Data_Out !== 8'h5A || Data_Valid !== 1'b1) begin
      errors++;
      $display("FAIL empty_follow got %h/%b want 5a/1",
               Data_Out, Data_Valid);
    end
  endtask

  task automatic test_reset_mid();
    for (int i = 0; i < 5; i++)
      cycle(1'b1, 1'b0, 1'b1, DW'($urandom), DW'($urandom));
    cycle(1'b1, 1'b1, 1'b1, DW'($urandom), DW'($urandom));
    @(negedge clk);
    Write = 0; Read = 0;
    reset = 1'b0;
    #1;
    q.delete(); e_out = '0;
    e_valid = 0; e_wd = 0; e_rd = 0;
    checks++;
    if (st !== model_st() || Data_Out !== '0) begin
      errors++;
      $display("FAIL reset_mid got %h/%h want %h/00",
               st, Data_Out, model_st());
    end
    @(negedge clk);
    reset = 1'b1;
    cycle(1'b1, 1'b0, 1'b0, 8'h00, 8'h77);
    cycle(1'b0, 1'b1, 1'b0, 8'h00, 8'h00);
    checks++;
    if (Data_Out !== 8'h77 || Data_Valid !== 1'b1 ||
        Empty !== 1'b1) begin
      errors++;
      $display("FAIL reset_first got %h/%b want 77/1",
               Data_Out, Data_Valid);
    end
  endtask

  task automatic test_random();
    for (int i = 0; i < 400; i++) begin
      cycle(1'($urandom), 1'($urandom_range(0, 2) != 0),
            1'($urandom), DW'($urandom), DW'($urandom));
      checks++;
      if (st !== e_st || Data_Out !== e_out) begin
        errors++;
        $display("FAIL random i=%0d got %h/%h want %h/%h",
                 i, st, Data_Out, e_st, e_out);
      end
    end
    for (int i = 0; i < 300; i++) begin
      cycle(1'($urandom_range(0, 3) != 0),
            1'($urandom_range(0, 3) == 0),
            1'($urandom), DW'($urandom), DW'($urandom));
      checks++;
      if (st !== e_st || Data_Out !== e_out) begin
        errors++;
        $display("FAIL random_fill i=%0d got %h/%h want %h/%h",
                 i, st, Data_Out, e_st, e_out);
      end
    end
  endtask

  initial begin
    test_reset();
    test_fill_overflow();
    test_drain_underflow();
    test_mux_select();
    test_back_to_back();
    test_empty_simul();
    test_reset_mid();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/dual_channel_fifo.md
Name: dual_channel_fifo

Overview:
- Data buffer on the far side of the two-channel load/read controller.
- Accepts Write/Read/Mux strobes and returns Full/Empty status.
- Mux selects which channel's input word is written: Ch1 when Mux=1, Ch2 when Mux=0.
- Stored words drain in arrival order on Read, with a registered output and a valid strobe for the downstream consumer.

Parameters:
- DATA_WIDTH, 8: width of each channel word and of Data_Out.
- DEPTH, 16: number of storage entries; must be a power of two, minimum 2.
- ADDR_WIDTH, 4: log2(DEPTH); pointer width.

Ports:
- clk  in  1  system clock, all state on rising edge
- reset  in  1  asynchronous, active-low reset
- Mux  in  1  write source select: 1 = Ch1_Data, 0 = Ch2_Data
- Write  in  1  write request, level, sampled each clk
- Read  in  1  read request, level, sampled each clk
- Ch1_Data  in  DATA_WIDTH  channel 1 input word
- Ch2_Data  in  DATA_WIDTH  channel 2 input word
- Data_Out  out  DATA_WIDTH  registered read data
- Data_Valid  out  1  one-cycle pulse; Data_Out holds a newly read word
- Full  out  1  Count == DEPTH
- Empty  out  1  Count == 0
- Count  out  ADDR_WIDTH+1  current occupancy, 0..DEPTH
- Write_Drop  out  1  one-cycle pulse; Write was asserted while Full and was not accepted
- Read_Drop  out  1  one-cycle pulse; Read was asserted while Empty and was not accepted

Behaviour:
- Reset (reset=0, asynchronous, takes effect immediately):
  - wr_ptr=0, rd_ptr=0, Count=0.
  - Data_Out=0, Data_Valid=0, Write_Drop=0, Read_Drop=0.
  - Empty=1, Full=0.
  - Storage array is not cleared.
  - Reset mid-operation discards all contents; the first write after release goes to entry 0.
- Acceptance, evaluated on the pre-edge Full/Empty:
  - wr_en = Write & ~Full
  - rd_en = Read & ~Empty
- Write path:
  - On wr_en, mem[wr_ptr] <= (Mux ? Ch1_Data : Ch2_Data).
  - wr_ptr increments and wraps DEPTH-1 -> 0 by natural ADDR_WIDTH overflow.
  - Mux is sampled in the same cycle as Write.
- Read path:
  - On rd_en, Data_Out <= mem[rd_ptr] and Data_Valid <= 1 on that edge.
  - Read latency is 1 clk.
  - rd_ptr increments with wrap.
  - Without rd_en, Data_Valid <= 0 and Data_Out holds its last value.
- Count:
  - +1 on wr_en only, -1 on rd_en only.
  - Unchanged on both or neither.
  - Never exceeds DEPTH and never underflows.
- Simultaneous Write and Read:
  - Empty: only the write is accepted. No read-before-write bypass; Read_Drop pulses.
  - Full: only the read is accepted; Write_Drop pulses.
  - Otherwise: both are accepted in the same cycle.
- Full and Empty are decoded from the Count register, so they are glitch-free and valid from the cycle after the causing edge.
- Drop pulses are registered and appear the cycle after the rejected request.
- The controller's Moore outputs keep Write high for the one cycle in which it observes Full. Likewise Read stays high for the cycle it observes Empty. A single Write_Drop per fill and a single Read_Drop per drain are therefore normal and carry no error meaning.
- Mux, Ch1_Data and Ch2_Data are don't-care when Write=0.

Decomposition:
- Shared package: DATA_WIDTH and DEPTH defaults, and ADDR_WIDTH derivation as a constant function. The same values are reused by the controller-level top.
- One sub-module: fifo_mem.
  - Simple dual-port register array with synchronous write and synchronous registered read.
  - Ports: clk, we, waddr, wdata, re, raddr, rdata.
- Pointer, count, flag and drop logic stay in dual_channel_fifo.

Test Plan:
1. Reset, then Write=1 Mux=1 Ch1_Data=8'hA0..8'hAF for 16 clks -> Count steps 1..16, Full=1 after the 16th edge. A 17th Write with Ch1=8'hFF gives Write_Drop=1 for one clk and Count stays 16.
2. From scenario 1 state, Read=1 for 17 clks -> Data_Out=8'hA0..8'hAF, each with Data_Valid=1 one clk after Read. Empty=1 after the 16th read; the 17th read gives Read_Drop=1 and Data_Out holds 8'hAF.
3. Interleave Mux=1 Ch1=8'h11, Mux=0 Ch2=8'h22, Mux=1 Ch1=8'h33, then drain -> output order 8'h11, 8'h22, 8'h33. The unselected channel's value never appears.
4. Fill with 10 words, then Write=1 and Read=1 together for 20 clks with incrementing data -> Count constant at 10, Full=0, Empty=0. Output order is strictly preserved across the pointer wrap (wr_ptr passes 15->0).
5. With Empty=1, assert Write and Read together (Ch2=8'h5A, Mux=0) -> Count=1, Read_Drop=1, Data_Valid=0. A next-cycle Read returns 8'h5A with Data_Valid=1.
6. Fill 5 words, pulse reset low mid-cycle for 1 clk -> Count=0, Empty=1, Data_Valid=0 immediately (asynchronous). The next write lands at entry 0 and is the first word read back.
